phys_reg_free_list_ckpt: RTL

- Parametrised physical-register free list for the rename stage: a circular FIFO of free phys_reg_tag_t values.
- Single-port dequeue to rename; multi-port enqueue from ROB commit (freed safe tags).
- Per-column checkpoint of the head pointer for single-cycle branch-mispredict restore.
- Supersedes the fixed-size, single-port free-list definition; depth, enqueue width and checkpoint count are all parameters.

---
 rtl/phys_reg_free_list_ckpt.sv | 91 +++++++++
 1 files changed

// File: rtl/phys_reg_free_list_ckpt.sv
// phys_reg_free_list_ckpt: circular free list of physical register tags with per-column head checkpoints.
// Optional same-cycle empty bypass from the lowest valid enqueue port under FREE_LIST_BYPASS_EN.
module phys_reg_free_list_ckpt #(
    parameter  int NUM_PHYS_REGS      = 64,
    parameter  int NUM_ARCH_REGS      = 32,
    parameter  int ENQ_PORTS          = 2,
    parameter  int CHECKPOINT_COLUMNS = 4,
    localparam int PHYS_REG_WIDTH     = $clog2(NUM_PHYS_REGS),
    localparam int DEPTH              = NUM_PHYS_REGS - NUM_ARCH_REGS,
    localparam int AW                 = $clog2(DEPTH),
    localparam int LOG_COLS           = (CHECKPOINT_COLUMNS > 1) ? $clog2(CHECKPOINT_COLUMNS) : 1
) (
    input  logic                                CLK,
    input  logic                                nRST,
    output logic                                dequeue_valid,
    input  logic                                dequeue_ready,
    output logic [PHYS_REG_WIDTH-1:0]           dequeue_phys_reg_tag,
    input  logic [ENQ_PORTS-1:0]                enqueue_valid,
    input  logic [ENQ_PORTS*PHYS_REG_WIDTH-1:0] enqueue_phys_reg_tag,
    input  logic                                save_valid,
    input  logic [LOG_COLS-1:0]                 save_column,
    input  logic                                restore_valid,
    input  logic [LOG_COLS-1:0]                 restore_column,
    output logic [AW:0]                         free_count,
    output logic                                empty,
    output logic                                full
);
    logic [PHYS_REG_WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]               r_saved [CHECKPOINT_COLUMNS];
    logic [AW:0]               r_head, r_tail;
    logic [AW:0]               w_count, w_pop, w_head_next, w_tail_next;
    logic [AW:0]               w_off [ENQ_PORTS];
    logic [AW:0]               w_widx [ENQ_PORTS];
    logic [ENQ_PORTS-1:0]      w_first;
    logic [PHYS_REG_WIDTH-1:0] w_byp_tag;
    logic                      w_byp, w_deq, w_adv, w_byp_take, w_drop;

    // Compaction: each valid port's slot offset is the number of valid ports below it.
    always_comb begin
        w_pop     = '0;
        w_first   = '0;
        w_byp_tag = '0;
        for (int p = 0; p < ENQ_PORTS; p++) begin
            w_off[p]   = w_pop;
            w_first[p] = enqueue_valid[p] && (w_pop == '0);
            w_byp_tag  = w_byp_tag | (w_first[p] ? enqueue_phys_reg_tag[p*PHYS_REG_WIDTH +: PHYS_REG_WIDTH] : '0);
            w_pop      = w_pop + (AW+1)'(enqueue_valid[p]);
        end
    end

    assign w_count    = r_tail - r_head;
    assign free_count = w_count;
    assign empty      = w_count == '0;
    assign full       = w_count == (AW+1)'(DEPTH);

`ifdef FREE_LIST_BYPASS_EN
    assign w_byp = empty && |enqueue_valid;
`else
    assign w_byp = 1'b0;
`endif

    assign dequeue_valid        = !empty || w_byp;
    assign dequeue_phys_reg_tag = empty ? w_byp_tag : r_mem[r_head[AW-1:0]];
    assign w_deq                = dequeue_valid && dequeue_ready && !restore_valid;
    assign w_adv                = w_deq && !empty;
    // A handshake while empty can only be the bypassed tag, which never lands in the array.
    assign w_byp_take           = w_deq && empty;
    assign w_drop               = ({1'b0, w_count} + {1'b0, w_pop}) > (AW+2)'(DEPTH);
    assign w_head_next          = restore_valid ? r_saved[restore_column] : r_head + (AW+1)'(w_adv);
    assign w_tail_next          = w_drop ? r_tail : r_tail + w_pop - (AW+1)'(w_byp_take);

    for (genvar p = 0; p < ENQ_PORTS; p++) begin : g_widx
        assign w_widx[p] = r_tail + w_off[p] - (AW+1)'(w_byp_take);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_head <= '0;
            r_tail <= (AW+1)'(DEPTH);
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= PHYS_REG_WIDTH'(NUM_ARCH_REGS + i);
            for (int c = 0; c < CHECKPOINT_COLUMNS; c++) r_saved[c] <= '0;
        end else begin
            r_head <= w_head_next;
            r_tail <= w_tail_next;
            if (save_valid && !restore_valid) r_saved[save_column] <= w_head_next;
            for (int p = 0; p < ENQ_PORTS; p++)
                if (enqueue_valid[p] && !w_drop && !(w_byp_take && w_first[p]))
                    r_mem[w_widx[p][AW-1:0]] <= enqueue_phys_reg_tag[p*PHYS_REG_WIDTH +: PHYS_REG_WIDTH];
        end
    end
endmodule
